// File: rtl/core_lapido_pkg.sv
// Shared timing constants for the core_lapido multi-cycle control path.
package core_lapido_pkg;

  localparam int CLK_PHASES = 5;
  localparam int PH_IF      = 0;
  localparam int PH_PCW     = CLK_PHASES - 1;
  localparam int CLK_CNT_W  = $clog2(CLK_PHASES);

endpackage

// File: rtl/clk_counter.sv
// Purpose: free-running modulo-PHASES phase counter decoded into if_enable / pc_write strobes.
// Latency: strobes are a combinational decode of the counter, zero cycles after the clock edge.
// Backpressure: none; the counter never stalls.
module clk_counter
  import core_lapido_pkg::*;
#(
  parameter int PHASES    = CLK_PHASES,
  parameter int CNT_W     = $clog2(PHASES),
  parameter int IF_PHASE  = PH_IF,
  parameter int PCW_PHASE = PHASES - 1
) (
  input  logic clk,
  input  logic rst,
  output logic if_enable,
  output logic pc_write
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PHASES - 1);
  localparam logic [CNT_W-1:0] IF_CNT   = CNT_W'(IF_PHASE);
  localparam logic [CNT_W-1:0] PCW_CNT  = CNT_W'(PCW_PHASE);

  logic [CNT_W-1:0] counter;

  // Using >= on the terminal count also pulls out-of-range values back to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
    end else if (counter >= LAST_CNT) begin
      counter <= '0;
    end else begin
      counter <= counter + 1'b1;
    end
  end

  assign if_enable = (counter == IF_CNT);
  assign pc_write  = (counter == PCW_CNT);

endmodule

// File: tb/tb_clk_counter.sv
// Randomized check of clk_counter at PHASES = 5, 3 and 8 against a cycles-since-reset model.
module tb_clk_counter;

  logic clk;
  logic rst;
  logic if5, pc5, if3, pc3, if8, pc8;

  int compared   = 0;
  int mismatched = 0;
  int n          = 0;  // clock edges seen since the last reset

  clk_counter u_dut5 (.clk(clk), .rst(rst), .if_enable(if5), .pc_write(pc5));
  clk_counter #(.PHASES(3)) u_dut3 (.clk(clk), .rst(rst), .if_enable(if3), .pc_write(pc3));
  clk_counter #(.PHASES(8)) u_dut8 (.clk(clk), .rst(rst), .if_enable(if8), .pc_write(pc8));

  initial begin
    clk = 1'b0;
    #20;
    forever begin
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) n = 0;
    else     n = n + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t, n=%0d)", tag, got, exp, $time, n);
    end
  endtask

  task automatic check_dut(input string tag, input int p, input int cnt, input logic ife, input logic pcw);
    check({tag, ".cnt"}, cnt, n % p);
    check({tag, ".if"},  int'(ife), int'(n % p == 0));
    check({tag, ".pcw"}, int'(pcw), int'(n % p == p - 1));
    check({tag, ".excl"}, int'(ife & pcw), 0);
  endtask

  task automatic check_all(input string tag);
    check_dut({tag, "/p5"}, 5, int'(u_dut5.counter), if5, pc5);
    check_dut({tag, "/p3"}, 3, int'(u_dut3.counter), if3, pc3);
    check_dut({tag, "/p8"}, 8, int'(u_dut8.counter), if8, pc8);
  endtask

  initial begin
    int prev;
    bit found;
    rst = 1'b0;

    // Asynchronous reset with the clock idle: no edge occurs before t=20.
    #10;
    rst = 1'b1;
    #1;
    check("areset.cnt", int'(u_dut5.counter), 0);
    check("areset.if", int'(if5), 1);
    check("areset.pcw", int'(pc5), 0);
    check_all("areset");
    rst = 1'b0;

    // First clocks after reset: 1,2,3 then the PC write phase, then wrap.
    prev = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("step.cnt", int'(u_dut5.counter), k % 5);
      if (k < 5) check("step.inc", int'(u_dut5.counter), prev + 1);
      check("step.if", int'(if5), int'(k == 5));
      check("step.pcw", int'(pc5), int'(k == 4));
      check_all("step");
      prev = int'(u_dut5.counter);
    end

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_all("run");
    end

    // Mid-sequence reset while the counter sits at 3.
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (u_dut5.counter == 3) found = 1'b1;
    end
    check("mid.found3", int'(found), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid.cnt", int'(u_dut5.counter), 0);
    check("mid.if", int'(if5), 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("mid.hold", int'(u_dut5.counter), 0);
      check_all("mid.hold");
    end
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid.first", int'(u_dut5.counter), 1);
    check_all("mid.first");

    // Random runs interleaved with random asynchronous resets.
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        #($urandom_range(1, 3));
        rst = 1'b1;
        #1;
        check_all("rnd.rst");
        repeat ($urandom_range(0, 2)) @(negedge clk);
        #($urandom_range(1, 3));
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 6)) begin
        @(negedge clk);
        check_all("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
